// File: rtl/isa_pkg.sv
// Shared ISA definitions for the multi-load/store expander: opcodes,
// instruction field positions, sequencer state type and micro-op builder.
package isa_pkg;

  localparam logic [3:0] OP_LW = 4'b0100;
  localparam logic [3:0] OP_SW = 4'b0101;
  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  localparam int unsigned OPC_HI  = 15;
  localparam int unsigned OPC_LO  = 12;
  localparam int unsigned RA_HI   = 11;
  localparam int unsigned RA_LO   = 9;
  localparam int unsigned RB_HI   = 8;
  localparam int unsigned RB_LO   = 6;
  localparam int unsigned IMM6_HI = 5;
  localparam int unsigned IMM6_LO = 0;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } seq_state_t;

  // Build one LW/SW micro-op: {op, Ri, RA, zero-extended offset}
  function automatic logic [15:0] make_uop(input logic       is_store,
                                           input logic [2:0] ri,
                                           input logic [2:0] ra,
                                           input logic [2:0] off);
    return {(is_store ? OP_SW : OP_LW), ri, ra, {3'b000, off}};
  endfunction

endpackage

// File: rtl/lowest_bit_enc.sv
// 8-bit priority encoder: index of the lowest set bit plus a valid flag.
module lowest_bit_enc (
  input  logic [7:0] vec,
  output logic [2:0] idx,
  output logic       valid
);

  // Scan upward; the first set bit found wins
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (vec[i] && !valid) begin
        idx   = 3'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_seq.sv
// LM/SM expander: replaces a load/store-multiple in IF/ID with a run of
// LW/SW micro-ops, one per set register-list bit, while freezing the PC.
// Optional micro-op counter enabled by defining MULTI_SEQ_STATS_EN.
module multi_seq
  import isa_pkg::*;
#(
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       pr1_IR,
  input  logic              stall,
  input  logic              flush,
  output logic [15:0]       new_IR_multi,
  output logic              IR_load_mux,
  output logic              multi_PCWrite,
  output logic              id_nop,
`ifdef MULTI_SEQ_STATS_EN
  output logic              busy,
  output logic [STAT_W-1:0] stat_count
`else
  output logic              busy
`endif
);

  seq_state_t state_q, state_d;
  logic [7:0] remain_q, remain_d;
  logic [2:0] offset_q, offset_d;
  logic [2:0] base_q, base_d;
  logic       kind_sm_q, kind_sm_d;

  logic [3:0] opcode;
  logic       is_multi;
  logic [7:0] enc_in;
  logic [2:0] enc_idx;
  logic       enc_valid;

  assign opcode   = pr1_IR[OPC_HI:OPC_LO];
  assign is_multi = (opcode == OP_LM) || (opcode == OP_SM);

  // One encoder serves both paths: the detect cycle looks at the incoming
  // list, EMIT looks at what is left of the latched list.
  assign enc_in = (state_q == EMIT) ? remain_q : pr1_IR[7:0];

  lowest_bit_enc u_enc (
    .vec   (enc_in),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // Sequencer state and latched instruction fields
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      remain_q  <= '0;
      offset_q  <= '0;
      base_q    <= '0;
      kind_sm_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      offset_q  <= offset_d;
      base_q    <= base_d;
      kind_sm_q <= kind_sm_d;
    end
  end

  // Next-state and fetch-override outputs; reset forces the idle values
  // combinationally so they do not wait for a clock edge.
  always_comb begin
    state_d       = state_q;
    remain_d      = remain_q;
    offset_d      = offset_q;
    base_d        = base_q;
    kind_sm_d     = kind_sm_q;
    new_IR_multi  = '0;
    IR_load_mux   = 1'b0;
    multi_PCWrite = 1'b1;
    id_nop        = 1'b0;
    busy          = 1'b0;

    if (!reset) begin
      // keep defaults
    end else if (flush) begin
      busy      = (state_q == EMIT);
      state_d   = IDLE;
      remain_d  = '0;
      offset_d  = '0;
      base_d    = '0;
      kind_sm_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (is_multi) begin
            id_nop = 1'b1;
            if (enc_valid) begin
              IR_load_mux   = 1'b1;
              multi_PCWrite = 1'b0;
              new_IR_multi  = make_uop(opcode == OP_SM, enc_idx,
                                       pr1_IR[RA_HI:RA_LO], 3'd0);
              if (!stall) begin
                remain_d  = pr1_IR[7:0] & ~(8'b1 << enc_idx);
                offset_d  = 3'd1;
                base_d    = pr1_IR[RA_HI:RA_LO];
                kind_sm_d = (opcode == OP_SM);
                state_d   = (remain_d != '0) ? EMIT : IDLE;
              end
            end
          end
        end
        EMIT: begin
          busy          = 1'b1;
          IR_load_mux   = 1'b1;
          multi_PCWrite = 1'b0;
          new_IR_multi  = make_uop(kind_sm_q, enc_idx, base_q, offset_q);
          if (!stall) begin
            remain_d = remain_q & ~(8'b1 << enc_idx);
            offset_d = offset_q + 3'd1;
            if (remain_d == '0) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef MULTI_SEQ_STATS_EN
  logic unused_ok;
  assign unused_ok = pr1_IR[RB_HI];

  // Count accepted micro-op loads, saturating at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_count <= '0;
    end else if (IR_load_mux && !stall && (stat_count != '1)) begin
      stat_count <= stat_count + 1'b1;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{pr1_IR[RB_HI], STAT_W[0]};
`endif

endmodule

// File: tb/tb_multi_seq.sv
// Directed bench for multi_seq; expected micro-ops are hand-derived.
module tb_multi_seq;

  logic        clk;
  logic        reset;
  logic [15:0] pr1_IR;
  logic        stall;
  logic        flush;
  logic [15:0] new_IR_multi;
  logic        IR_load_mux;
  logic        multi_PCWrite;
  logic        id_nop;
  logic        busy;
`ifdef MULTI_SEQ_STATS_EN
  logic [15:0] stat_count;
`endif

  int total = 0;
  int bad   = 0;

  multi_seq #(.STAT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .pr1_IR        (pr1_IR),
    .stall         (stall),
    .flush         (flush),
    .new_IR_multi  (new_IR_multi),
    .IR_load_mux   (IR_load_mux),
    .multi_PCWrite (multi_PCWrite),
    .id_nop        (id_nop),
`ifdef MULTI_SEQ_STATS_EN
    .busy          (busy),
    .stat_count    (stat_count)
`else
    .busy          (busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic expect_o(input string tag, input logic [15:0] e_ir,
                          input logic e_ld, input logic e_pcw,
                          input logic e_nop, input logic e_busy);
    check_val($sformatf("%s.ir", tag),   32'(new_IR_multi),  32'(e_ir));
    check_val($sformatf("%s.ld", tag),   32'(IR_load_mux),   32'(e_ld));
    check_val($sformatf("%s.pcw", tag),  32'(multi_PCWrite), 32'(e_pcw));
    check_val($sformatf("%s.nop", tag),  32'(id_nop),        32'(e_nop));
    check_val($sformatf("%s.busy", tag), 32'(busy),          32'(e_busy));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply(input logic [15:0] ir, input logic st, input logic fl);
    pr1_IR = ir;
    stall  = st;
    flush  = fl;
    #1;
  endtask

  // SM R7, list 0xFF: micro-op i is 0x51C0 + i*0x0201
  function automatic logic [15:0] sm7_uop(input int i);
    return 16'h51C0 + 16'(i) * 16'h0201;
  endfunction

  int low_cnt;

  initial begin
    reset  = 1'b0;
    pr1_IR = 16'h0000;
    stall  = 1'b0;
    flush  = 1'b0;
    #1;
    expect_o("rst", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    tick();

    // SM R7 full list: eight stores
    low_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      apply((i == 0) ? 16'h7EFF : sm7_uop(i - 1), 1'b0, 1'b0);
      expect_o($sformatf("sm_full%0d", i), sm7_uop(i), 1'b1, 1'b0,
               (i == 0), (i != 0));
      if (multi_PCWrite == 1'b0) low_cnt++;
      tick();
    end
    apply(sm7_uop(7), 1'b0, 1'b0);
    expect_o("sm_full_end", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("sm_full_pc_low", 32'(low_cnt), 32'd8);
`ifdef MULTI_SEQ_STATS_EN
    check_val("stat8", 32'(stat_count), 32'd8);
`endif
    tick();

    // LM R2, list 0x05
    apply(16'h6405, 1'b0, 1'b0);
    expect_o("lm0", 16'h4080, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    apply(16'h4080, 1'b0, 1'b0);
    expect_o("lm1", 16'h4481, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    apply(16'h4481, 1'b0, 1'b0);
    expect_o("lm_end", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();

    // Empty list: one-cycle bubble, no injection
    apply(16'h6400, 1'b0, 1'b0);
    expect_o("empty0", 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    apply(16'h1234, 1'b0, 1'b0);
    expect_o("empty1", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();

    // Stall three cycles on the second micro-op
    apply(16'h7EFF, 1'b0, 1'b0);
    expect_o("st_det", 16'h51C0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      apply(16'h51C0, 1'b1, 1'b0);
      expect_o($sformatf("st_hold%0d", k), 16'h53C1, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
    end
    apply(16'h51C0, 1'b0, 1'b0);
    expect_o("st_rel", 16'h53C1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    for (int i = 2; i < 8; i++) begin
      apply(sm7_uop(i - 1), 1'b0, 1'b0);
      expect_o($sformatf("st_seq%0d", i), sm7_uop(i), 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
    end
    apply(sm7_uop(7), 1'b0, 1'b0);
    expect_o("st_end", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();

    // Flush during the fourth micro-op
    for (int i = 0; i < 3; i++) begin
      apply((i == 0) ? 16'h7EFF : sm7_uop(i - 1), 1'b0, 1'b0);
      expect_o($sformatf("fl_pre%0d", i), sm7_uop(i), 1'b1, 1'b0,
               (i == 0), (i != 0));
      tick();
    end
    apply(sm7_uop(2), 1'b0, 1'b1);
    check_val("fl_now.ld",  32'(IR_load_mux),   32'd0);
    check_val("fl_now.pcw", 32'(multi_PCWrite), 32'd1);
    check_val("fl_now.nop", 32'(id_nop),        32'd0);
    tick();
    apply(16'h0000, 1'b0, 1'b0);
    expect_o("fl_after", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    apply(16'h6405, 1'b0, 1'b0);
    expect_o("fl_lm0", 16'h4080, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    apply(16'h4080, 1'b0, 1'b0);
    expect_o("fl_lm1", 16'h4481, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    apply(16'h4481, 1'b0, 1'b0);
    expect_o("fl_lm_end", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();

    // Asynchronous reset mid-EMIT
    apply(16'h7EFF, 1'b0, 1'b0);
    tick();
    apply(16'h51C0, 1'b0, 1'b0);
    expect_o("ar_pre", 16'h53C1, 1'b1, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    expect_o("ar_low", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef MULTI_SEQ_STATS_EN
    check_val("ar_stat", 32'(stat_count), 32'd0);
`endif
    apply(16'h6405, 1'b0, 1'b0);
    expect_o("ar_lm_in_rst", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    #1 reset = 1'b1;
    #1;
    expect_o("ar_lm0", 16'h4080, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    apply(16'h4080, 1'b0, 1'b0);
    expect_o("ar_lm1", 16'h4481, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    apply(16'h4481, 1'b0, 1'b0);
    expect_o("ar_lm_end", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
